cache_lru_repl: RTL and testbench

//  Parametrised true-LRU replacement controller for set-associative caches (icache, dcache, TLB).

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_lru_set.sv | 122 ++++++++++++
 rtl/cache_lru_repl.sv | 116 +++++++++++
 tb/tb_cache_lru_repl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache replacement logic: index-width helpers
// and the widest age type used inside the victim search.
package cache_pkg;

  // Largest supported associativity and the age width it needs.
  localparam int MAX_WAYS  = 16;
  localparam int MAX_AGE_W = 4;

  // Age value wide enough for any supported associativity.
  typedef logic [MAX_AGE_W-1:0] lru_age_t;

  // Width of a set index; a single-set cache still carries a 1-bit index.
  function automatic int set_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Width of a way index (and of a per-way age).
  function automatic int way_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/cache_lru_set.sv
// One set's true-LRU age vector. Ages are a permutation of 0..NUM_WAYS-1
// (0 = MRU). Touch promotes a way to MRU, invalidate demotes it to LRU.
// The victim search works on the post-update ages so a touch or invalidate
// in the same cycle as a request is already reflected in the answer.
module cache_lru_set
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = way_w(NUM_WAYS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                touch_en,
  input  logic [WAY_W-1:0]    touch_way,
  input  logic                inval_en,
  input  logic [WAY_W-1:0]    inval_way,
  input  logic [NUM_WAYS-1:0] valid_mask,
  input  logic [NUM_WAYS-1:0] lock_mask,
  output logic [WAY_W-1:0]    victim_way,
  output logic                victim_none
);

  logic [WAY_W-1:0] age_r     [NUM_WAYS];
  logic [WAY_W-1:0] age_nxt_s [NUM_WAYS];
  logic [WAY_W-1:0] touch_old_s;
  logic [WAY_W-1:0] inval_old_s;
  logic             inv_found_s;
  logic [WAY_W-1:0] inv_way_s;
  logic             unl_found_s;
  logic [WAY_W-1:0] unl_way_s;
  lru_age_t         unl_age_s;

  // Fetch the current age of the touched and invalidated ways.
  always_comb begin
    touch_old_s = '0;
    inval_old_s = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      touch_old_s = touch_old_s | (age_r[w] & {WAY_W{WAY_W'(w) == touch_way}});
      inval_old_s = inval_old_s | (age_r[w] & {WAY_W{WAY_W'(w) == inval_way}});
    end
  end

  // Next ages: touch takes priority; the top level never enables both.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      age_nxt_s[w] = age_r[w];
    end
    if (touch_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == touch_way) begin
          age_nxt_s[w] = '0;
        end else if (age_r[w] < touch_old_s) begin
          age_nxt_s[w] = age_r[w] + WAY_W'(1);
        end else begin
          age_nxt_s[w] = age_r[w];
        end
      end
    end else if (inval_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == inval_way) begin
          age_nxt_s[w] = WAY_W'(NUM_WAYS - 1);
        end else if (age_r[w] > inval_old_s) begin
          age_nxt_s[w] = age_r[w] - WAY_W'(1);
        end else begin
          age_nxt_s[w] = age_r[w];
        end
      end
    end else begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        age_nxt_s[w] = age_r[w];
      end
    end
  end

  // Age register; reset leaves way 0 as LRU and the last way as MRU.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        age_r[w] <= WAY_W'(NUM_WAYS - 1 - w);
      end
    end else begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        age_r[w] <= age_nxt_s[w];
      end
    end
  end

  // Victim search: first free unlocked way, else oldest unlocked way.
  always_comb begin
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    unl_found_s = 1'b0;
    unl_way_s   = '0;
    unl_age_s   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!inv_found_s && !valid_mask[w] && !lock_mask[w]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_W'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
      if (!lock_mask[w] && (!unl_found_s || (lru_age_t'(age_nxt_s[w]) > unl_age_s))) begin
        unl_found_s = 1'b1;
        unl_way_s   = WAY_W'(w);
        unl_age_s   = lru_age_t'(age_nxt_s[w]);
      end else begin
        unl_found_s = unl_found_s;
      end
    end
    if (inv_found_s) begin
      victim_way  = inv_way_s;
      victim_none = 1'b0;
    end else if (unl_found_s) begin
      victim_way  = unl_way_s;
      victim_none = 1'b0;
    end else begin
      victim_way  = '0;
      victim_none = 1'b1;
    end
  end

endmodule

// File: rtl/cache_lru_repl.sv
// True-LRU replacement controller: one age vector per set, touch/invalidate
// updates from the cache controller, and a registered victim answer one
// cycle after each victim_req. Out-of-range set or way indices are ignored.
module cache_lru_repl
  import cache_pkg::*;
#(
  parameter  int NUM_SETS = 64,
  parameter  int NUM_WAYS = 4,
  localparam int SET_W    = set_w(NUM_SETS),
  localparam int WAY_W    = way_w(NUM_WAYS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                victim_req,
  input  logic [SET_W-1:0]    victim_set,
  input  logic [NUM_WAYS-1:0] victim_valid_mask,
  input  logic [NUM_WAYS-1:0] victim_lock_mask,
  output logic                victim_rsp,
  output logic [WAY_W-1:0]    victim_way,
  output logic                victim_none,
  input  logic                touch_req,
  input  logic [SET_W-1:0]    touch_set,
  input  logic [WAY_W-1:0]    touch_way,
  input  logic                inval_req,
  input  logic [SET_W-1:0]    inval_set,
  input  logic [WAY_W-1:0]    inval_way
);

  // Compared one bit wider so a power-of-two count does not wrap to zero.
  localparam logic [SET_W:0] SET_LIM = (SET_W + 1)'(NUM_SETS);
  localparam logic [WAY_W:0] WAY_LIM = (WAY_W + 1)'(NUM_WAYS);

  logic                touch_ok_s;
  logic                inval_ok_s;
  logic                victim_ok_s;
  logic [NUM_SETS-1:0] touch_hit_s;
  logic [NUM_SETS-1:0] inval_hit_s;
  logic [WAY_W-1:0]    set_way_s  [NUM_SETS];
  logic                set_none_s [NUM_SETS];
  logic [WAY_W-1:0]    sel_way_s;
  logic                sel_none_s;
  logic                victim_rsp_r;
  logic [WAY_W-1:0]    victim_way_r;
  logic                victim_none_r;

  // Range-check incoming indices.
  always_comb begin
    touch_ok_s  = touch_req && ({1'b0, touch_set} < SET_LIM) && ({1'b0, touch_way} < WAY_LIM);
    inval_ok_s  = inval_req && ({1'b0, inval_set} < SET_LIM) && ({1'b0, inval_way} < WAY_LIM);
    victim_ok_s = {1'b0, victim_set} < SET_LIM;
  end

  // Per-set enables; a touch to the same set suppresses the invalidate.
  always_comb begin
    touch_hit_s = '0;
    inval_hit_s = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      touch_hit_s[s] = touch_ok_s && (touch_set == SET_W'(s));
      inval_hit_s[s] = inval_ok_s && (inval_set == SET_W'(s)) && !touch_hit_s[s];
    end
  end

  for (genvar g = 0; g < NUM_SETS; g++) begin : g_set
    cache_lru_set #(
      .NUM_WAYS (NUM_WAYS),
      .WAY_W    (WAY_W)
    ) u_set (
      .clock       (clock),
      .reset       (reset),
      .touch_en    (touch_hit_s[g]),
      .touch_way   (touch_way),
      .inval_en    (inval_hit_s[g]),
      .inval_way   (inval_way),
      .valid_mask  (victim_valid_mask),
      .lock_mask   (victim_lock_mask),
      .victim_way  (set_way_s[g]),
      .victim_none (set_none_s[g])
    );
  end

  // Pick the addressed set's victim; an out-of-range set has no victim.
  always_comb begin
    sel_way_s  = '0;
    sel_none_s = 1'b1;
    if (victim_ok_s) begin
      sel_way_s  = set_way_s[victim_set];
      sel_none_s = set_none_s[victim_set];
    end else begin
      sel_way_s  = '0;
      sel_none_s = 1'b1;
    end
  end

  // Response register: strobe every request cycle, hold way/none between.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      victim_rsp_r  <= 1'b0;
      victim_way_r  <= '0;
      victim_none_r <= 1'b0;
    end else begin
      victim_rsp_r <= victim_req;
      if (victim_req) begin
        victim_way_r  <= sel_way_s;
        victim_none_r <= sel_none_s;
      end else begin
        victim_way_r  <= victim_way_r;
        victim_none_r <= victim_none_r;
      end
    end
  end

  assign victim_rsp  = victim_rsp_r;
  assign victim_way  = victim_way_r;
  assign victim_none = victim_none_r;

endmodule

// File: tb/tb_cache_lru_repl.sv
// Directed vector table plus hand-written reset and random-traffic
// sequences for cache_lru_repl (12 sets, 4 ways).
module tb_cache_lru_repl;

  localparam int NS = 12;
  localparam int NW = 4;

  logic       clock;
  logic       reset;
  logic       victim_req;
  logic [3:0] victim_set;
  logic [3:0] victim_valid_mask;
  logic [3:0] victim_lock_mask;
  logic       victim_rsp;
  logic [1:0] victim_way;
  logic       victim_none;
  logic       touch_req;
  logic [3:0] touch_set;
  logic [1:0] touch_way;
  logic       inval_req;
  logic [3:0] inval_set;
  logic [1:0] inval_way;

  int checks;
  int failures;

  cache_lru_repl #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clock             (clock),
    .reset             (reset),
    .victim_req        (victim_req),
    .victim_set        (victim_set),
    .victim_valid_mask (victim_valid_mask),
    .victim_lock_mask  (victim_lock_mask),
    .victim_rsp        (victim_rsp),
    .victim_way        (victim_way),
    .victim_none       (victim_none),
    .touch_req         (touch_req),
    .touch_set         (touch_set),
    .touch_way         (touch_way),
    .inval_req         (inval_req),
    .inval_set         (inval_set),
    .inval_way         (inval_way)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       t_req;
    logic [3:0] t_set;
    logic [1:0] t_way;
    logic       i_req;
    logic [3:0] i_set;
    logic [1:0] i_way;
    logic       v_req;
    logic [3:0] v_set;
    logic [3:0] valid;
    logic [3:0] lock;
    logic       e_rsp;
    logic [1:0] e_way;
    logic       e_none;
  } vec_t;

  vec_t vecs[30];

  // Reference ages for the random phase.
  int age_m [NS][NW];

  function automatic vec_t mk(int tr, int ts, int tw, int ir, int is, int iw,
                              int vr, int vs, int va, int lk, int er, int ew, int en);
    vec_t v;
    v.t_req = tr[0];   v.t_set = ts[3:0]; v.t_way = tw[1:0];
    v.i_req = ir[0];   v.i_set = is[3:0]; v.i_way = iw[1:0];
    v.v_req = vr[0];   v.v_set = vs[3:0]; v.valid = va[3:0]; v.lock = lk[3:0];
    v.e_rsp = er[0];   v.e_way = ew[1:0]; v.e_none = en[0];
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    touch_req = v.t_req; touch_set = v.t_set; touch_way = v.t_way;
    inval_req = v.i_req; inval_set = v.i_set; inval_way = v.i_way;
    victim_req = v.v_req; victim_set = v.v_set;
    victim_valid_mask = v.valid; victim_lock_mask = v.lock;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic m_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        age_m[s][w] = NW - 1 - w;
  endtask

  task automatic m_touch(input int s, input int u);
    int a;
    a = age_m[s][u];
    for (int w = 0; w < NW; w++) begin
      if (w == u) age_m[s][w] = 0;
      else if (age_m[s][w] < a) age_m[s][w] = age_m[s][w] + 1;
    end
  endtask

  task automatic m_inval(input int s, input int u);
    int a;
    a = age_m[s][u];
    for (int w = 0; w < NW; w++) begin
      if (w == u) age_m[s][w] = NW - 1;
      else if (age_m[s][w] > a) age_m[s][w] = age_m[s][w] - 1;
    end
  endtask

  task automatic m_victim(input int s, input logic [3:0] va, input logic [3:0] lk,
                          output int way, output int none);
    int best;
    way = 0; none = 1; best = -1;
    if (s < NS) begin
      for (int w = NW - 1; w >= 0; w--)
        if (!va[w] && !lk[w]) begin way = w; none = 0; end
      if (none == 1) begin
        for (int w = 0; w < NW; w++)
          if (!lk[w] && age_m[s][w] > best) begin best = age_m[s][w]; way = w; none = 0; end
      end
    end
  endtask

  initial begin
    vec_t v;
    int   exp_way;
    int   exp_none;
    int   ts, tw, is, iw, vs;
    logic tr, ir, vr;
    logic [3:0] va, lk;
    bit   t_eff;

    checks = 0;
    failures = 0;

    // tr ts tw ir is iw vr vs valid lock | rsp way none
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 15, 0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0);
    vecs[2]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0);
    vecs[3]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0);
    vecs[4]  = mk(1, 5, 2, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0);
    vecs[5]  = mk(1, 5, 3, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 15, 0, 1, 0, 0);
    vecs[7]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 15, 0, 1, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 11, 0, 1, 2, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 5, 15, 15, 1, 0, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 3, 1, 2, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 5, 15, 2, 1, 2, 0);
    vecs[13] = mk(1, 7, 0, 0, 0, 0, 0, 0, 15, 0, 0, 2, 0);
    vecs[14] = mk(1, 7, 1, 0, 0, 0, 0, 0, 15, 0, 0, 2, 0);
    vecs[15] = mk(1, 7, 2, 0, 0, 0, 1, 7, 15, 0, 1, 3, 0);
    vecs[16] = mk(1, 1, 0, 0, 0, 0, 0, 0, 15, 0, 0, 3, 0);
    vecs[17] = mk(1, 1, 1, 0, 0, 0, 0, 0, 15, 0, 0, 3, 0);
    vecs[18] = mk(1, 1, 2, 0, 0, 0, 0, 0, 15, 0, 0, 3, 0);
    vecs[19] = mk(1, 1, 3, 0, 0, 0, 0, 0, 15, 0, 0, 3, 0);
    vecs[20] = mk(0, 0, 0, 1, 1, 3, 0, 0, 15, 0, 0, 3, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 1, 15, 0, 1, 3, 0);
    vecs[22] = mk(1, 1, 0, 1, 1, 1, 1, 1, 15, 0, 1, 3, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 1, 1, 15, 8, 1, 1, 0);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 1, 13, 15, 0, 1, 0, 1);
    vecs[25] = mk(1, 13, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 1);
    vecs[26] = mk(1, 2, 0, 1, 3, 3, 1, 3, 15, 0, 1, 3, 0);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 1, 2, 15, 0, 1, 1, 0);
    vecs[28] = mk(1, 2, 0, 0, 0, 0, 1, 2, 15, 0, 1, 1, 0);
    vecs[29] = mk(0, 0, 0, 0, 0, 0, 1, 2, 15, 2, 1, 2, 0);

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0));
    reset = 1'b1;
    #12;
    check("reset_rsp", int'(victim_rsp), 0);
    check("reset_way", int'(victim_way), 0);
    check("reset_none", int'(victim_none), 0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      check($sformatf("vec%0d_rsp", i), int'(victim_rsp), int'(vecs[i].e_rsp));
      check($sformatf("vec%0d_way", i), int'(victim_way), int'(vecs[i].e_way));
      check($sformatf("vec%0d_none", i), int'(victim_none), int'(vecs[i].e_none));
    end

    // Reset lands between a request and its response: nothing comes back.
    drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 15, 0, 0, 0, 0));
    #3 reset = 1'b1;
    #3 victim_req = 1'b0;
    step();
    check("rst_mid_rsp", int'(victim_rsp), 0);
    #2 reset = 1'b0;
    step();
    check("rst_after_rsp", int'(victim_rsp), 0);
    check("rst_after_way", int'(victim_way), 0);
    check("rst_after_none", int'(victim_none), 0);

    // Sets 1 and 7 were reordered above; reset puts way 0 back as LRU.
    drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 15, 0, 0, 0, 0));
    step();
    check("rst_set1_way", int'(victim_way), 0);
    check("rst_set1_rsp", int'(victim_rsp), 1);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 7, 15, 0, 0, 0, 0));
    step();
    check("rst_set7_way", int'(victim_way), 0);
    check("rst_set7_none", int'(victim_none), 0);

    // Random traffic against the reference ages.
    m_reset();
    exp_way = 0;
    exp_none = 0;
    for (int c = 0; c < 400; c++) begin
      tr = ($urandom_range(0, 1) == 1);
      ts = $urandom_range(0, 15);
      tw = $urandom_range(0, 3);
      ir = ($urandom_range(0, 2) == 0);
      is = ($urandom_range(0, 1) == 1) ? ts : $urandom_range(0, 15);
      iw = $urandom_range(0, 3);
      vr = ($urandom_range(0, 2) != 0);
      vs = ($urandom_range(0, 1) == 1) ? ts : $urandom_range(0, 15);
      va = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      lk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;

      t_eff = tr && (ts < NS);
      if (t_eff) m_touch(ts, tw);
      if (ir && (is < NS) && !(t_eff && ts == is)) m_inval(is, iw);
      if (vr) m_victim(vs, va, lk, exp_way, exp_none);

      drive(mk(int'(tr), ts, tw, int'(ir), is, iw, int'(vr), vs, int'(va), int'(lk), 0, 0, 0));
      step();
      check($sformatf("rnd%0d_rsp", c), int'(victim_rsp), int'(vr));
      check($sformatf("rnd%0d_way", c), int'(victim_way), exp_way);
      check($sformatf("rnd%0d_none", c), int'(victim_none), exp_none);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
